regfile_write_arbiter: RTL and testbench

Owns the single write port of the 32x32 register file and shares it between two writeback sources: requester 0 (ALU writeback) and requester 1 (load/memory writeback). After reset it runs a clear sequence that zeroes all 32 registers. It then arbitrates round-robin between the requesters using a valid/ready handshake. Its outputs connect directly to the register file's wrEnable/wrReg/wrData inputs.

---
 rtl/regfile_write_arbiter.sv | 103 ++++++++++
 tb/tb_regfile_write_arbiter.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/regfile_write_arbiter.sv
// Single write port of the 32x32 register file, shared round-robin by ALU and load writeback; zeroes the file after reset.
// Latency: a write accepted in cycle N drives wrEnable/wrReg/wrData during cycle N+1. Up to one write per cycle.
// Backpressure: each ready is high only for the granted requester in RUN. Both readies stay low during reset and clear.
module regfile_write_arbiter #(
    parameter int NUM_REGS       = 32,
    parameter bit CLEAR_ON_RESET = 1'b1,
    parameter bit ZERO_R0        = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [4:0]  req0_reg,
    input  logic [31:0] req0_data,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [4:0]  req1_reg,
    input  logic [31:0] req1_data,
    output logic        wrEnable,
    output logic [4:0]  wrReg,
    output logic [31:0] wrData,
    output logic        init_done
);

    typedef enum logic {CLEAR, RUN} state_t;

    localparam logic [4:0] LAST_REG = 5'(NUM_REGS - 1);

    state_t      state, stateNext;
    logic [4:0]  clrCnt, clrCntNext;
    logic        lastGrant;
    logic        running;
    logic        grantVld;
    logic        grantIdx;
    logic        handshake;
    logic [4:0]  selReg;
    logic [31:0] selData;

    // init_done also masks the single RUN cycle that follows reset when the clear is skipped
    assign running = (state == RUN) && init_done;

    always_comb begin
        grantVld = 1'b0;
        grantIdx = 1'b0;
        if (req0_valid && req1_valid) begin
            grantVld = 1'b1;
            grantIdx = ~lastGrant;
        end else if (req0_valid) begin
            grantVld = 1'b1;
            grantIdx = 1'b0;
        end else if (req1_valid) begin
            grantVld = 1'b1;
            grantIdx = 1'b1;
        end
    end

    assign req0_ready = running && grantVld && !grantIdx;
    assign req1_ready = running && grantVld && grantIdx;
    assign handshake  = running && grantVld;
    assign selReg     = grantIdx ? req1_reg  : req0_reg;
    assign selData    = grantIdx ? req1_data : req0_data;

    always_comb begin
        stateNext  = state;
        clrCntNext = clrCnt;
        if (state == CLEAR) begin
            clrCntNext = clrCnt + 5'd1;
            if (clrCnt == LAST_REG) begin
                stateNext = RUN;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= CLEAR_ON_RESET ? CLEAR : RUN;
            clrCnt    <= 5'd0;
            lastGrant <= 1'b1;
            wrEnable  <= 1'b0;
            wrReg     <= 5'd0;
            wrData    <= 32'd0;
            init_done <= 1'b0;
        end else begin
            state     <= stateNext;
            clrCnt    <= clrCntNext;
            init_done <= (stateNext == RUN);
            if (state == CLEAR) begin
                wrEnable <= 1'b1;
                wrReg    <= clrCnt;
                wrData   <= 32'd0;
            end else if (handshake) begin
                // r0 writes are still accepted so the requester never stalls on them
                wrEnable  <= !(ZERO_R0 && (selReg == 5'd0));
                wrReg     <= selReg;
                wrData    <= selData;
                lastGrant <= grantIdx;
            end else begin
                wrEnable <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter with a behavioural register file on its write port.
module tb_regfile_write_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req0_valid = 1'b0;
    logic        req0_ready;
    logic [4:0]  req0_reg = 5'd0;
    logic [31:0] req0_data = 32'd0;
    logic        req1_valid = 1'b0;
    logic        req1_ready;
    logic [4:0]  req1_reg = 5'd0;
    logic [31:0] req1_data = 32'd0;
    logic        wrEnable;
    logic [4:0]  wrReg;
    logic [31:0] wrData;
    logic        init_done;

    logic [31:0] rf [32];

    int testsRun    = 0;
    int testsFailed = 0;

    regfile_write_arbiter dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_reg   (req0_reg),
        .req0_data  (req0_data),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_reg   (req1_reg),
        .req1_data  (req1_data),
        .wrEnable   (wrEnable),
        .wrReg      (wrReg),
        .wrData     (wrData),
        .init_done  (init_done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (wrEnable === 1'b1) rf[wrReg] <= wrData;
    end

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        testsRun++;
        if (got !== exp) begin
            testsFailed++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Reset, then walk the clear sequence; optionally re-assert rst once when register abortAt is presented.
    task automatic runClear(input int abortAt);
        int  k;
        bit  aborted;
        aborted = 1'b0;
        rst = 1'b1;
        tick;
        checkVal("rstEn",   {31'd0, wrEnable}, 32'd0);
        checkVal("rstReg",  {27'd0, wrReg}, 32'd0);
        checkVal("rstData", wrData, 32'd0);
        checkVal("rstInit", {31'd0, init_done}, 32'd0);
        checkVal("rstRdy",  {30'd0, req0_ready, req1_ready}, 32'd0);
        rst = 1'b0;
        req0_valid = 1'b1; req0_reg = 5'd4; req0_data = 32'h4444_4444;
        req1_valid = 1'b1; req1_reg = 5'd6; req1_data = 32'h6666_6666;
        k = 0;
        while (k < 32) begin
            tick;
            checkVal("clrEn",   {31'd0, wrEnable}, 32'd1);
            checkVal("clrReg",  {27'd0, wrReg}, 32'(k));
            checkVal("clrData", wrData, 32'd0);
            checkVal("clrInit", {31'd0, init_done}, (k == 31) ? 32'd1 : 32'd0);
            if (k < 31) checkVal("clrRdy", {30'd0, req0_ready, req1_ready}, 32'd0);
            if (k == abortAt && !aborted) begin
                aborted = 1'b1;
                rst = 1'b1;
                tick;
                checkVal("midRstEn",   {31'd0, wrEnable}, 32'd0);
                checkVal("midRstReg",  {27'd0, wrReg}, 32'd0);
                checkVal("midRstInit", {31'd0, init_done}, 32'd0);
                checkVal("midRstRdy",  {30'd0, req0_ready, req1_ready}, 32'd0);
                rst = 1'b0;
                k = 0;
            end else begin
                k++;
            end
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        tick;
        checkVal("postClrEn", {31'd0, wrEnable}, 32'd0);
        for (int i = 0; i < 32; i++) checkVal($sformatf("rfZero%0d", i), rf[i], 32'd0);
    endtask

    // Present one write on a single requester and follow it into the file.
    task automatic singleWrite(input bit who, input logic [4:0] r, input logic [31:0] d, input bit expEn);
        if (who) begin
            req1_valid = 1'b1; req1_reg = r; req1_data = d;
        end else begin
            req0_valid = 1'b1; req0_reg = r; req0_data = d;
        end
        #1;
        checkVal("sglRdy", {30'd0, req0_ready, req1_ready}, who ? 32'd1 : 32'd2);
        tick;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        checkVal("sglEn",   {31'd0, wrEnable}, {31'd0, expEn});
        checkVal("sglReg",  {27'd0, wrReg}, {27'd0, r});
        checkVal("sglData", wrData, d);
        tick;
        checkVal("sglIdleEn", {31'd0, wrEnable}, 32'd0);
        checkVal("sglHoldReg", {27'd0, wrReg}, {27'd0, r});
    endtask

    logic [4:0]  q0Reg  [3] = '{5'd1, 5'd2, 5'd3};
    logic [31:0] q0Data [3] = '{32'hA000_0001, 32'hA000_0002, 32'hA000_0003};
    logic [4:0]  q1Reg  [3] = '{5'd11, 5'd12, 5'd13};
    logic [31:0] q1Data [3] = '{32'hB000_000B, 32'hB000_000C, 32'hB000_000D};

    initial begin
        int i0;
        int i1;
        bit expGrant;

        runClear(-1);

        singleWrite(1'b0, 5'd5, 32'hDEAD_BEEF, 1'b1);
        checkVal("rf5", rf[5], 32'hDEAD_BEEF);

        // req1 granted last, then idle cycles must not move priority
        singleWrite(1'b1, 5'd7, 32'h0000_0077, 1'b1);
        checkVal("rf7", rf[7], 32'h0000_0077);
        tick; tick; tick;

        i0 = 0;
        i1 = 0;
        for (int c = 0; c < 6; c++) begin
            req0_valid = 1'b1; req0_reg = q0Reg[i0]; req0_data = q0Data[i0];
            req1_valid = 1'b1; req1_reg = q1Reg[i1]; req1_data = q1Data[i1];
            expGrant = (c % 2 == 1);
            #1;
            checkVal($sformatf("rrRdy%0d", c), {30'd0, req0_ready, req1_ready}, expGrant ? 32'd1 : 32'd2);
            tick;
            checkVal($sformatf("rrEn%0d", c), {31'd0, wrEnable}, 32'd1);
            if (expGrant) begin
                checkVal($sformatf("rrReg%0d", c), {27'd0, wrReg}, {27'd0, q1Reg[i1]});
                checkVal($sformatf("rrData%0d", c), wrData, q1Data[i1]);
                i1++;
            end else begin
                checkVal($sformatf("rrReg%0d", c), {27'd0, wrReg}, {27'd0, q0Reg[i0]});
                checkVal($sformatf("rrData%0d", c), wrData, q0Data[i0]);
                i0++;
            end
            if (i0 > 2) i0 = 2;
            if (i1 > 2) i1 = 2;
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        tick;
        checkVal("rrIdleEn", {31'd0, wrEnable}, 32'd0);
        for (int j = 0; j < 3; j++) begin
            checkVal($sformatf("rfA%0d", j), rf[q0Reg[j]], q0Data[j]);
            checkVal($sformatf("rfB%0d", j), rf[q1Reg[j]], q1Data[j]);
        end

        singleWrite(1'b1, 5'd0, 32'h0000_1234, 1'b0);
        checkVal("rf0", rf[0], 32'd0);

        // same destination back to back: req0 goes first, req1's data must survive
        req0_valid = 1'b1; req0_reg = 5'd9; req0_data = 32'h0000_0001;
        req1_valid = 1'b1; req1_reg = 5'd9; req1_data = 32'h0000_0002;
        #1;
        checkVal("sameRdy0", {30'd0, req0_ready, req1_ready}, 32'd2);
        tick;
        req0_valid = 1'b0;
        #1;
        checkVal("sameRdy1", {30'd0, req0_ready, req1_ready}, 32'd1);
        tick;
        req1_valid = 1'b0;
        tick;
        checkVal("rf9", rf[9], 32'h0000_0002);

        runClear(10);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, tests run %0d", testsRun);
        $fatal(1, "watchdog expired");
    end

endmodule
